// File: rtl/trig_capture_seq.sv
// Capture sequencer: sample-rate divider, pre-trigger fill, level/edge/auto trigger.
// Ports: CLK/nRST, ADC stream + trigger config in, Arm/Force/Abort/Write_Ready in; CLK_EN/Start_Write/event_in/status out.
module trig_capture_seq #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16,
  parameter int PRE_W  = 18,
  parameter int AUTO_W = 20
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DATA_W-1:0] ADC_DATA,
  input  logic [DATA_W-1:0] TRIG_LEVEL,
  input  logic              TRIG_EDGE,
  input  logic              AUTO_EN,
  input  logic [AUTO_W-1:0] AUTO_TIME,
  input  logic [DIV_W-1:0]  SR_DIV,
  input  logic [PRE_W-1:0]  PRE_DATA,
  input  logic              Arm,
  input  logic              Force,
  input  logic              Abort,
  input  logic              Write_Ready,
  output logic              CLK_EN,
  output logic              Start_Write,
  output logic              event_in,
  output logic              Busy,
  output logic              Capture_Done,
  output logic              Auto_Fired
);

  typedef enum logic [2:0] {
    IDLE, PRETRIG, ARMED, POST, DONE, RESTART
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [AUTO_W-1:0] to_cnt;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  logic rise;
  logic fall;
  logic edge_hit;
  logic to_hit;
  logic pre_hit;
  logic clr;
  logic fire_auto;
  logic active_nxt;

  always_comb begin
    rise = CLK_EN && prev_valid &&
           (prev < TRIG_LEVEL) && (ADC_DATA >= TRIG_LEVEL);
    fall = CLK_EN && prev_valid &&
           (prev >= TRIG_LEVEL) && (ADC_DATA < TRIG_LEVEL);
    edge_hit = TRIG_EDGE ? fall : rise;
    // Fires on the sample that brings the count up to AUTO_TIME;
    // a zero timeout fires on the first sample.
    to_hit = CLK_EN && AUTO_EN &&
             ((AUTO_TIME == '0) ||
              (to_cnt + AUTO_W'(1) == AUTO_TIME));
    pre_hit = (pre_cnt == PRE_DATA);
  end

  always_comb begin
    nxt       = state;
    clr       = 1'b0;
    fire_auto = 1'b0;
    if (Abort) begin
      nxt = IDLE;
    end else if (Arm) begin
      clr = 1'b1;
      nxt = (state == IDLE || state == RESTART) ? PRETRIG : RESTART;
    end else begin
      unique case (state)
        IDLE:    nxt = IDLE;
        PRETRIG: if (pre_hit) nxt = ARMED;
        ARMED: begin
          if (Force) begin
            nxt       = POST;
            fire_auto = 1'b1;
          end else if (edge_hit) begin
            nxt = POST;
          end else if (to_hit) begin
            nxt       = POST;
            fire_auto = 1'b1;
          end
        end
        POST:    if (Write_Ready) nxt = DONE;
        DONE:    nxt = DONE;
        RESTART: begin
          nxt = PRETRIG;
          clr = 1'b1;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Divider restarts at 0 on entry to an active state, so the first
  // enable lands SR_DIV cycles after the session begins.
  always_comb begin
    active_nxt = (nxt != IDLE) && (nxt != RESTART);
    if (!active_nxt || CLK_EN || state == IDLE || state == RESTART)
      div_nxt = '0;
    else
      div_nxt = div_cnt + DIV_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      div_cnt      <= '0;
      pre_cnt      <= '0;
      to_cnt       <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      CLK_EN       <= 1'b0;
      Start_Write  <= 1'b0;
      event_in     <= 1'b0;
      Busy         <= 1'b0;
      Capture_Done <= 1'b0;
      Auto_Fired   <= 1'b0;
    end else begin
      state   <= nxt;
      div_cnt <= div_nxt;
      // >= keeps the divider from running to wrap if SR_DIV drops below the count
      CLK_EN  <= active_nxt && (div_nxt >= SR_DIV);

      if (clr) begin
        pre_cnt    <= '0;
        to_cnt     <= '0;
        prev_valid <= 1'b0;
        Auto_Fired <= 1'b0;
      end else begin
        if (CLK_EN) begin
          prev       <= ADC_DATA;
          prev_valid <= 1'b1;
        end
        if (state == PRETRIG && CLK_EN && !pre_hit)
          pre_cnt <= pre_cnt + PRE_W'(1);
        if (state == ARMED && CLK_EN && AUTO_EN)
          to_cnt <= to_cnt + AUTO_W'(1);
        if (fire_auto)
          Auto_Fired <= 1'b1;
      end

      Start_Write  <= (nxt == PRETRIG) || (nxt == ARMED) ||
                      (nxt == POST) || (nxt == DONE);
      event_in     <= (nxt == POST);
      Busy         <= (nxt != IDLE) && (nxt != DONE);
      Capture_Done <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_trig_capture_seq.sv
// Directed bench for trig_capture_seq.
// Drives vectors 1ns after each rising edge and checks registered outputs there.
module tb_trig_capture_seq;

  logic        CLK;
  logic        nRST;
  logic [7:0]  ADC_DATA;
  logic [7:0]  TRIG_LEVEL;
  logic        TRIG_EDGE;
  logic        AUTO_EN;
  logic [19:0] AUTO_TIME;
  logic [15:0] SR_DIV;
  logic [17:0] PRE_DATA;
  logic        Arm;
  logic        Force;
  logic        Abort;
  logic        Write_Ready;
  logic        CLK_EN;
  logic        Start_Write;
  logic        event_in;
  logic        Busy;
  logic        Capture_Done;
  logic        Auto_Fired;

  int n_chk;
  int n_fail;

  trig_capture_seq dut (
    .CLK(CLK), .nRST(nRST), .ADC_DATA(ADC_DATA),
    .TRIG_LEVEL(TRIG_LEVEL), .TRIG_EDGE(TRIG_EDGE),
    .AUTO_EN(AUTO_EN), .AUTO_TIME(AUTO_TIME),
    .SR_DIV(SR_DIV), .PRE_DATA(PRE_DATA),
    .Arm(Arm), .Force(Force), .Abort(Abort),
    .Write_Ready(Write_Ready), .CLK_EN(CLK_EN),
    .Start_Write(Start_Write), .event_in(event_in),
    .Busy(Busy), .Capture_Done(Capture_Done),
    .Auto_Fired(Auto_Fired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_arm();
    Arm = 1'b1;
    step();
    Arm = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    nRST = 1'b0;
    ADC_DATA = '0;
    TRIG_LEVEL = 8'h80;
    TRIG_EDGE = 1'b0;
    AUTO_EN = 1'b0;
    AUTO_TIME = '0;
    SR_DIV = 16'd3;
    PRE_DATA = 18'd100;
    Arm = 1'b0;
    Force = 1'b0;
    Abort = 1'b0;
    Write_Ready = 1'b0;

    step();
    step();
    check("rst_clk_en", CLK_EN, 0);
    check("rst_sw", Start_Write, 0);
    check("rst_ev", event_in, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Capture_Done, 0);
    check("rst_af", Auto_Fired, 0);
    nRST = 1'b1;

    // divider period SR_DIV+1, Force ignored outside ARMED
    step();
    check("idle_clk_en", CLK_EN, 0);
    pulse_arm();
    check("arm_sw", Start_Write, 1);
    check("arm_busy", Busy, 1);
    for (int i = 1; i <= 12; i++) begin
      check("div4", CLK_EN, (i % 4 == 0));
      check("force_ign", event_in, 0);
      Force = (i == 5);
      step();
    end
    Force = 1'b0;
    SR_DIV = 16'd0;
    step();
    for (int i = 0; i < 6; i++) begin
      check("div1", CLK_EN, 1);
      step();
    end

    // rising edge on ramp after 5 pre-trigger samples
    PRE_DATA = 18'd5;
    ADC_DATA = 8'h00;
    pulse_arm();
    check("restart_sw", Start_Write, 0);
    check("restart_busy", Busy, 1);
    check("restart_clk_en", CLK_EN, 0);
    step();
    for (int k = 0; k < 16; k++) begin
      ADC_DATA = 8'(k * 16);
      step();
      check("ramp_ev", event_in, (k >= 8));
      check("ramp_sw", Start_Write, 1);
    end

    // async reset mid-POST
    #3;
    nRST = 1'b0;
    #1;
    check("ar_clk_en", CLK_EN, 0);
    check("ar_sw", Start_Write, 0);
    check("ar_ev", event_in, 0);
    check("ar_busy", Busy, 0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ar_idle_en", CLK_EN, 0);
      check("ar_idle_sw", Start_Write, 0);
    end

    // crossing during pre-trigger fill is ignored
    pulse_arm();
    for (int k = 0; k <= 10; k++) begin
      ADC_DATA = 8'(8'h50 + k * 16);
      step();
      check("pre_ign", event_in, 0);
    end
    ADC_DATA = 8'h10;
    step();
    check("low_ev", event_in, 0);
    ADC_DATA = 8'h90;
    step();
    check("edge2_ev", event_in, 1);
    check("edge2_af", Auto_Fired, 0);

    // window complete, DONE, then re-arm through RESTART
    Write_Ready = 1'b1;
    step();
    check("done_cd", Capture_Done, 1);
    check("done_ev", event_in, 0);
    check("done_sw", Start_Write, 1);
    check("done_busy", Busy, 0);
    step();
    check("done_hold", Capture_Done, 1);
    Write_Ready = 1'b0;
    pulse_arm();
    check("rs_sw", Start_Write, 0);
    check("rs_cd", Capture_Done, 0);
    check("rs_busy", Busy, 1);
    step();
    check("rs_pre_sw", Start_Write, 1);
    step();
    check("rs_pre_sw2", Start_Write, 1);

    // Force from ARMED
    ADC_DATA = 8'hF0;
    for (int i = 0; i < 8; i++) step();
    check("pre_force_ev", event_in, 0);
    Force = 1'b1;
    step();
    Force = 1'b0;
    check("force_ev", event_in, 1);
    check("force_af", Auto_Fired, 1);
    pulse_arm();
    check("arm_clr_af", Auto_Fired, 0);

    // falling mode, flat signal, auto trigger after 10 samples
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_sw", Start_Write, 0);
    TRIG_EDGE = 1'b1;
    ADC_DATA = 8'h40;
    AUTO_EN = 1'b1;
    AUTO_TIME = 20'd10;
    PRE_DATA = 18'd0;
    pulse_arm();
    for (int i = 1; i <= 11; i++) begin
      step();
      check("auto_ev", event_in, (i == 11));
    end
    check("auto_af", Auto_Fired, 1);

    // same without auto: stays ARMED; Write_Ready ignored
    AUTO_EN = 1'b0;
    pulse_arm();
    step();
    for (int i = 0; i < 40; i++) begin
      Write_Ready = (i == 20);
      step();
      check("noauto_ev", event_in, 0);
      check("noauto_cd", Capture_Done, 0);
    end
    Write_Ready = 1'b0;
    check("noauto_busy", Busy, 1);

    // Abort beats Arm and Force
    Abort = 1'b1;
    Arm = 1'b1;
    Force = 1'b1;
    step();
    Abort = 1'b0;
    Arm = 1'b0;
    Force = 1'b0;
    check("prio_sw", Start_Write, 0);
    check("prio_busy", Busy, 0);
    check("prio_ev", event_in, 0);
    check("prio_clk_en", CLK_EN, 0);

    // edge and timeout on the same sample: edge wins
    TRIG_EDGE = 1'b0;
    AUTO_EN = 1'b1;
    AUTO_TIME = 20'd3;
    ADC_DATA = 8'h00;
    pulse_arm();
    step();
    step();
    check("tie_pre_ev", event_in, 0);
    step();
    ADC_DATA = 8'h80;
    step();
    check("tie_ev", event_in, 1);
    check("tie_af", Auto_Fired, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
